// File: rtl/spi_arb_pkg.sv
// ---------------------------------------------------------------------------
// spi_arb_pkg
//
// Shared definitions for the two-master Wishbone arbiter in front of the
// simple_spi register port:
//   arb_state_t          - arbiter FSM encoding (ARB_IDLE / ARB_BUSY)
//   SPI_ARB_CNT_W        - width of the optional ack-timeout wait counter
//   SPI_ARB_TIMEOUT_DEF  - default TIMEOUT parameter value
//   SPI_REG_*            - simple_spi register offsets, for requesters/benches
// ---------------------------------------------------------------------------
package spi_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int SPI_ARB_CNT_W       = 8;
    localparam int SPI_ARB_TIMEOUT_DEF = 255;

    // simple_spi register map
    localparam logic [2:0] SPI_REG_SPCR = 3'd0;  // control
    localparam logic [2:0] SPI_REG_SPSR = 3'd1;  // status
    localparam logic [2:0] SPI_REG_SPDR = 3'd2;  // data
    localparam logic [2:0] SPI_REG_SPER = 3'd3;  // extensions
    localparam logic [2:0] SPI_REG_SSN  = 3'd4;  // slave select

endpackage

// File: rtl/spi_wb_arb_wdog.sv
// ---------------------------------------------------------------------------
// spi_wb_arb_wdog
//
// Ack-timeout wait counter for spi_wb_arbiter. Only instantiated when the
// arbiter is built with SPI_WB_ARB_TIMEOUT_EN defined.
//
// The counter runs while the arbiter is BUSY and the owner strobes without
// an ack. When it reaches TIMEOUT, `expire` is high for that cycle and the
// counter clears on the next edge, so a strobe that stays up restarts the
// count from zero.
//
// Ports:
//   clk, rstn    - clock, asynchronous active-low reset
//   busy         - arbiter is in ARB_BUSY
//   stb          - owner's cyc & stb
//   ack          - target ack
//   expire       - wait count has reached TIMEOUT this cycle
// ---------------------------------------------------------------------------
module spi_wb_arb_wdog
    import spi_arb_pkg::*;
#(
    parameter int TIMEOUT = SPI_ARB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic busy,
    input  logic stb,
    input  logic ack,
    output logic expire
);

    localparam logic [SPI_ARB_CNT_W-1:0] LIMIT = SPI_ARB_CNT_W'(TIMEOUT);

    logic [SPI_ARB_CNT_W-1:0] cnt;

    assign expire = busy & stb & (cnt == LIMIT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!busy || !stb || ack || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_wb_arbiter.sv
// ---------------------------------------------------------------------------
// spi_wb_arbiter
//
// Round-robin arbiter that lets two Wishbone masters share the single
// simple_spi register port. Master 0 is the AHB-to-Wishbone bridge, master 1
// an on-chip requester (boot loader / DMA). Arbitration happens per Wishbone
// cycle: the grant is held for as long as the owner keeps cyc high, so a
// multi-register SPI sequence cannot be interleaved with the other master.
//
// Handshake: a master requests by raising cyc; a transfer is offered while
// cyc & stb are high and completes in the cycle the target returns ack.
// Only the owner's cyc/stb reach the target, and ack/read data are routed
// back to the owner only. The non-owner just waits (ack/err/rty/dat = 0).
//
// Optional build macro: SPI_WB_ARB_TIMEOUT_EN adds an ack-timeout watchdog
// (spi_wb_arb_wdog). On expiry the owner gets a one-cycle err and t_stb_o
// is dropped for that cycle. Without the macro err outputs are tied to 0
// and TIMEOUT has no effect.
//
// Parameters: AW address width, DW data width, TIMEOUT ack wait (1..255).
// Ports:
//   clk, rstn                      - clock, asynchronous active-low reset
//   m0_* / m1_*                    - Wishbone slave ports for masters 0 and 1
//   t_*                            - Wishbone master port to the SPI core
//   gnt_o                          - one-hot current owner, 00 when idle
// ---------------------------------------------------------------------------
module spi_wb_arbiter
    import spi_arb_pkg::*;
#(
    parameter int AW      = 3,
    parameter int DW      = 8,
    parameter int TIMEOUT = SPI_ARB_TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic          m0_rty_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          m1_rty_o,

    output logic          t_cyc_o,
    output logic          t_stb_o,
    output logic          t_we_o,
    output logic [AW-1:0] t_adr_o,
    output logic [DW-1:0] t_dat_o,
    input  logic [DW-1:0] t_dat_i,
    input  logic          t_ack_i,

    output logic [1:0]    gnt_o
);

    arb_state_t state;
    logic       owner;   // 0 = master 0, 1 = master 1
    logic       last;    // owner of the most recently finished cycle

    logic          busy;
    logic          own_cyc;
    logic          own_stb;
    logic          own_we;
    logic [AW-1:0] own_adr;
    logic [DW-1:0] own_dat;
    logic          pick;
    logic          wd_expire;

    assign busy = (state == ARB_BUSY);

    always_comb begin
        own_cyc = owner ? m1_cyc_i : m0_cyc_i;
        own_stb = owner ? m1_stb_i : m0_stb_i;
        own_we  = owner ? m1_we_i  : m0_we_i;
        own_adr = owner ? m1_adr_i : m0_adr_i;
        own_dat = owner ? m1_dat_i : m0_dat_i;
    end

    // On a tie the master that did not own the previous cycle wins.
    assign pick = (m0_cyc_i & m1_cyc_i) ? ~last : m1_cyc_i;

    // FSM: state, owner, last and the registered grant vector.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ARB_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            gnt_o <= 2'b00;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (m0_cyc_i || m1_cyc_i) begin
                        state <= ARB_BUSY;
                        owner <= pick;
                        gnt_o <= pick ? 2'b10 : 2'b01;
                    end
                end
                ARB_BUSY: begin
                    if (!own_cyc) begin
                        state <= ARB_IDLE;
                        last  <= owner;
                        gnt_o <= 2'b00;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt_o <= 2'b00;
                end
            endcase
        end
    end

`ifdef SPI_WB_ARB_TIMEOUT_EN
    spi_wb_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rstn   (rstn),
        .busy   (busy),
        .stb    (own_cyc & own_stb),
        .ack    (t_ack_i),
        .expire (wd_expire)
    );
    // A late ack in the expiry cycle takes precedence over the error.
    assign m0_err_o = busy & ~owner & wd_expire & ~t_ack_i;
    assign m1_err_o = busy &  owner & wd_expire & ~t_ack_i;
`else
    assign wd_expire = 1'b0;
    assign m0_err_o  = 1'b0;
    assign m1_err_o  = 1'b0;
`endif

    // Target side: combinational from the owner, all zero while idle. Since
    // `busy` comes straight from an async-reset flop, reset kills the
    // target cycle without waiting for a clock edge.
    assign t_cyc_o = busy & own_cyc;
    assign t_stb_o = busy & own_cyc & own_stb & ~wd_expire;
    assign t_we_o  = busy & own_we;
    assign t_adr_o = busy ? own_adr : '0;
    assign t_dat_o = busy ? own_dat : '0;

    // Return path: ack and read data go to the owner only.
    assign m0_ack_o = busy & ~owner & t_ack_i;
    assign m1_ack_o = busy &  owner & t_ack_i;
    assign m0_dat_o = m0_ack_o ? t_dat_i : '0;
    assign m1_dat_o = m1_ack_o ? t_dat_i : '0;

    assign m0_rty_o = 1'b0;
    assign m1_rty_o = 1'b0;

endmodule

// File: tb/tb_spi_wb_arbiter.sv
// Directed bench for spi_wb_arbiter. Inputs change 1 ns after the rising
// edge, outputs are checked 1 ns later. Expected values are hand-derived.
module tb_spi_wb_arbiter;
    import spi_arb_pkg::*;

    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_err_o, m0_rty_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_err_o, m1_rty_o;
    logic          t_cyc_o, t_stb_o, t_we_o;
    logic [AW-1:0] t_adr_o;
    logic [DW-1:0] t_dat_o;
    logic [DW-1:0] t_dat_i;
    logic          t_ack_i;
    logic [1:0]    gnt_o;

    int checks = 0;
    int errors = 0;

    spi_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .t_cyc_o(t_cyc_o), .t_stb_o(t_stb_o), .t_we_o(t_we_o),
        .t_adr_o(t_adr_o), .t_dat_o(t_dat_o), .t_dat_i(t_dat_i),
        .t_ack_i(t_ack_i), .gnt_o(gnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
    endtask

    task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        logic exp_own;
        logic exp_err;

        rstn = 1'b0;
        drive_m0(0, 0, 0, '0, '0);
        drive_m1(0, 0, 0, '0, '0);
        t_dat_i = '0;
        t_ack_i = 1'b0;

        // ---- reset state ----
        #2;
        check("rst_gnt", {6'd0, gnt_o}, 8'h00);
        check("rst_tcyc", {7'd0, t_cyc_o}, 8'h00);
        check("rst_tstb", {7'd0, t_stb_o}, 8'h00);
        check("rst_m0ack", {7'd0, m0_ack_o}, 8'h00);
        check("rst_rty", {6'd0, m1_rty_o, m0_rty_o}, 8'h00);
        tick();
        rstn = 1'b1;

        // ---- both request in the same cycle after reset: master 0 first ----
        tick();
        drive_m0(1, 0, 0, '0, '0);
        drive_m1(1, 0, 0, SPI_REG_SSN, '0);
        #1;
        check("tie_idle_gnt", {6'd0, gnt_o}, 8'h00);
        tick();
        check("tie_first_gnt", {6'd0, gnt_o}, 8'h01);
        check("tie_first_tcyc", {7'd0, t_cyc_o}, 8'h01);
        tick();
        drive_m0(0, 0, 0, '0, '0);                 // release in cycle R
        #1;
        check("tie_rel_tcyc", {7'd0, t_cyc_o}, 8'h00);
        tick();                                    // R+1: dead cycle
        check("tie_dead_gnt", {6'd0, gnt_o}, 8'h00);
        tick();                                    // R+2: master 1
        check("tie_second_gnt", {6'd0, gnt_o}, 8'h02);
        check("tie_second_tadr", {5'd0, t_adr_o}, {5'd0, SPI_REG_SSN});
        drive_m1(0, 0, 0, '0, '0);
        tick();
        tick();
        check("tie_back_idle", {6'd0, gnt_o}, 8'h00);

        // ---- master 0 alone: write 0x50 to SPCR, ack one cycle after stb ----
        do_reset();
        tick();
        drive_m0(1, 1, 1, SPI_REG_SPCR, 8'h50);
        #1;
        check("w_idle_tstb", {7'd0, t_stb_o}, 8'h00);
        tick();                                    // N+1
        check("w_gnt", {6'd0, gnt_o}, 8'h01);
        check("w_tstb", {7'd0, t_stb_o}, 8'h01);
        check("w_twe", {7'd0, t_we_o}, 8'h01);
        check("w_tadr", {5'd0, t_adr_o}, 8'h00);
        check("w_tdat", t_dat_o, 8'h50);
        check("w_noack", {7'd0, m0_ack_o}, 8'h00);
        tick();
        t_ack_i = 1'b1;
        #1;
        check("w_ack", {7'd0, m0_ack_o}, 8'h01);
        check("w_m1_noack", {7'd0, m1_ack_o}, 8'h00);
        tick();
        t_ack_i = 1'b0;
        drive_m0(0, 0, 0, '0, '0);
        #1;
        check("w_ack_one_cycle", {7'd0, m0_ack_o}, 8'h00);
        check("w_rel_tcyc", {7'd0, t_cyc_o}, 8'h00);
        tick();
        check("w_rel_gnt", {6'd0, gnt_o}, 8'h00);

        // ---- master 0 locked sequence of 3 strobes, master 1 waits ----
        // last = 0 now, so a tie would go to master 1; master 0 asks first.
        tick();
        drive_m0(1, 1, 1, SPI_REG_SPCR, 8'h52);
        tick();
        drive_m1(1, 1, 1, SPI_REG_SPER, 8'h11);
        t_ack_i = 1'b1;
        #1;
        check("seq_gnt", {6'd0, gnt_o}, 8'h01);
        check("seq1_tadr", {5'd0, t_adr_o}, {5'd0, SPI_REG_SPCR});
        check("seq1_m0ack", {7'd0, m0_ack_o}, 8'h01);
        check("seq1_m1ack", {7'd0, m1_ack_o}, 8'h00);
        tick();
        drive_m0(1, 1, 1, SPI_REG_SPDR, 8'hA5);
        #1;
        check("seq2_tadr", {5'd0, t_adr_o}, {5'd0, SPI_REG_SPDR});
        check("seq2_tdat", t_dat_o, 8'hA5);
        check("seq2_m1ack", {7'd0, m1_ack_o}, 8'h00);
        tick();
        drive_m0(1, 1, 0, SPI_REG_SPSR, 8'h00);
        t_dat_i = 8'h80;
        #1;
        check("seq3_twe", {7'd0, t_we_o}, 8'h00);
        check("seq3_rdat", m0_dat_o, 8'h80);
        check("seq3_m1dat", m1_dat_o, 8'h00);
        check("seq3_m1ack", {7'd0, m1_ack_o}, 8'h00);
        tick();
        t_ack_i = 1'b0;
        drive_m0(1, 0, 0, SPI_REG_SPSR, 8'h00);
        #1;
        check("seq_dat_gated", m0_dat_o, 8'h00);
        tick();
        drive_m0(0, 0, 0, '0, '0);
        #1;
        check("seq_rel_tcyc", {7'd0, t_cyc_o}, 8'h00);
        check("seq_rel_m1ack", {7'd0, m1_ack_o}, 8'h00);
        tick();
        check("seq_dead_gnt", {6'd0, gnt_o}, 8'h00);
        tick();
        check("seq_m1_gnt", {6'd0, gnt_o}, 8'h02);
        check("seq_m1_tadr", {5'd0, t_adr_o}, {5'd0, SPI_REG_SPER});
        drive_m1(0, 0, 0, '0, '0);
        tick();

        // ---- continuous dual requests: strict alternation from master 0 ----
        // last = 1 after master 1 released.
        drive_m0(1, 1, 1, SPI_REG_SPDR, 8'h0F);
        drive_m1(1, 1, 1, SPI_REG_SSN, 8'hF0);
        exp_own = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("alt%0d_gnt", i), {6'd0, gnt_o}, exp_own ? 8'h02 : 8'h01);
            check($sformatf("alt%0d_tdat", i), t_dat_o, exp_own ? 8'hF0 : 8'h0F);
            t_ack_i = 1'b1;
            #1;
            check($sformatf("alt%0d_ack", i), {6'd0, m1_ack_o, m0_ack_o},
                  exp_own ? 8'h02 : 8'h01);
            tick();
            t_ack_i = 1'b0;
            if (exp_own) drive_m1(0, 0, 0, '0, '0);
            else         drive_m0(0, 0, 0, '0, '0);
            #1;
            check($sformatf("alt%0d_gap", i), {7'd0, t_cyc_o}, 8'h00);
            tick();
            check($sformatf("alt%0d_idle", i), {6'd0, gnt_o}, 8'h00);
            drive_m0(1, 1, 1, SPI_REG_SPDR, 8'h0F);
            drive_m1(1, 1, 1, SPI_REG_SSN, 8'hF0);
            exp_own = ~exp_own;
        end
        drive_m0(0, 0, 0, '0, '0);
        drive_m1(0, 0, 0, '0, '0);
        do_reset();

        // ---- master 1 strobes, target never acks ----
        tick();
        drive_m1(1, 1, 1, SPI_REG_SPDR, 8'h3C);
        for (int k = 0; k <= 5; k++) begin
            tick();                                // cycle S+k
`ifdef SPI_WB_ARB_TIMEOUT_EN
            exp_err = (k == 4);
`else
            exp_err = 1'b0;
`endif
            check($sformatf("to%0d_m1err", k), {7'd0, m1_err_o}, {7'd0, exp_err});
            check($sformatf("to%0d_tstb", k), {7'd0, t_stb_o}, {7'd0, ~exp_err});
            check($sformatf("to%0d_m0err", k), {7'd0, m0_err_o}, 8'h00);
            check($sformatf("to%0d_gnt", k), {6'd0, gnt_o}, 8'h02);
        end
        drive_m1(0, 0, 0, '0, '0);
        tick();
        check("to_rel_gnt", {6'd0, gnt_o}, 8'h00);

        // ---- async reset in the middle of a BUSY cycle ----
        tick();
        drive_m0(1, 1, 1, SPI_REG_SPCR, 8'h77);
        tick();
        check("ar_busy_tcyc", {7'd0, t_cyc_o}, 8'h01);
        t_ack_i = 1'b1;
        #1;
        rstn = 1'b0;                               // well away from any edge
        #1;
        check("ar_tcyc", {7'd0, t_cyc_o}, 8'h00);
        check("ar_tstb", {7'd0, t_stb_o}, 8'h00);
        check("ar_gnt", {6'd0, gnt_o}, 8'h00);
        check("ar_m0ack", {7'd0, m0_ack_o}, 8'h00);
        t_ack_i = 1'b0;
        drive_m0(0, 0, 0, '0, '0);
        tick();
        rstn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_wb_arbiter.md
# spi_wb_arbiter

Two-port Wishbone arbiter that shares the single `simple_spi_top` register port between the AHB-to-Wishbone bridge (master 0) and an on-chip SPI requester such as a boot loader or DMA engine (master 1). It sits between the bridge's Wishbone master port and the SPI core in the LEON3 passthrough design. Arbitration is round-robin at Wishbone-cycle granularity. A grant is held for as long as the owner keeps `cyc` asserted, so multi-register SPI sequences are atomic.

## Interface
- `AW`, 3: register address width forwarded to the target.
- `DW`, 8: data width.
- `TIMEOUT`, 255: maximum wait cycles for a target ack (1..255). Used only when the timeout watchdog is compiled in.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset. Asynchronous assertion, active-low.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 Wishbone cycle, strobe and write enable.
- `m0_adr_i` in AW: master 0 address.
- `m0_dat_i` in DW: master 0 write data.
- `m0_dat_o` out DW: master 0 read data.
- `m0_ack_o`, `m0_err_o`, `m0_rty_o` out 1 each: master 0 ack, error and retry.
- `m1_*`: same set of signals as `m0_*`, for master 1.
- `t_cyc_o`, `t_stb_o`, `t_we_o` out 1 each: target cycle, strobe and write enable.
- `t_adr_o` out AW: target address.
- `t_dat_o` out DW: target write data.
- `t_dat_i` in DW: target read data.
- `t_ack_i` in 1: target ack.
- `gnt_o` out 2: one-hot current owner, for debug. `00` means idle.

## Operation
- State machine has two states, IDLE and BUSY, plus an `owner` bit and a `last` bit.
- Reset: state IDLE, `owner` = 0, `last` = 1, so master 0 wins the first tie. All outputs are 0.

IDLE:
- A request is `mX_cyc_i` high.
- One requester: next state BUSY, `owner` = X.
- Both requesting: `owner` = !`last`.
- Target outputs are 0 in IDLE.

BUSY:
- Target bus is a combinational mux of the owner's signals (`cyc`, `stb`, `we`, `adr`, `dat`).
- `t_ack_i` and `t_dat_i` are routed to the owner only.
- The non-owner sees `ack`/`err`/`rty` = 0 and `dat_o` = 0. It simply waits and is never errored.
- When the owner drops `cyc`: next state IDLE and `last` = `owner`.

General rules:
- The target `cyc` never covers two owners.
- `rty_o` is always 0. It is reserved.
- `m0_dat_o` and `m1_dat_o` are zero whenever their `ack` is low.

## Timing
- Grant latency: request seen at edge N, BUSY from N+1.
- First target strobe is in cycle N+1. This gives one cycle of arbitration latency.
- Ack path from `t_ack_i` to `mX_ack_o` is combinational, zero cycles.
- Release: owner drops `cyc` in cycle R, IDLE in R+1, next grant in R+2. There is at least one dead cycle between owners.
- Both masters requesting continuously alternate strictly: 0, 1, 0, 1, ...
- Requester drops `cyc` while waiting (not owner): the request is simply withdrawn and no state changes.
- Async reset mid-transfer: `t_cyc_o`/`t_stb_o` drop immediately. The target sees an aborted cycle, which is acceptable because the SPI core register write has not completed without ack.

## Configuration
- `SPI_WB_ARB_TIMEOUT_EN` defined:
  - An 8-bit wait counter runs in BUSY. It clears on `t_ack_i` and whenever the owner's `stb` is low, and increments while owner `stb` is high and ack is low.
  - When the count reaches `TIMEOUT`: `mX_err_o` pulses for one cycle to the owner, `t_stb_o` is forced low in that same cycle, and the counter clears.
  - The arbiter stays BUSY until the owner drops `cyc`.
  - `err` and `ack` are never both high. If `t_ack_i` arrives in the timeout cycle, ack wins and err is suppressed.
- Macro undefined: no counter, `err` outputs tied 0, and `TIMEOUT` is ignored.

## Structure
- Shared package `spi_arb_pkg`:
  - state enum: `ARB_IDLE`, `ARB_BUSY`
  - `SPI_ARB_CNT_W` = 8
  - default `TIMEOUT` constant
  - simple_spi register offsets (SPCR 0, SPSR 1, SPDR 2, SPER 3, SSN 4), for benches and requesters.
- Optional sub-module `spi_wb_arb_wdog`, holding the timeout counter, instantiated only under the macro. All other logic stays in one module.

## Test plan
- Master 0 only: write 0x50 to adr 0, target acks 1 cycle after stb. Expect `t_adr_o` = 0, `t_dat_o` = 0x50, `m0_ack_o` for 1 cycle, and `gnt_o` = 01 from cycle N+1.
- Both masters request in the same cycle after reset. Expect master 0 granted first. Master 1 is granted 2 cycles after master 0 drops `cyc`. Then `last` = 1.
- Master 0 holds `cyc` across 3 strobes (SPCR, SPDR, SPSR read returning 0x80) while master 1 requests. Expect master 1 `ack` = 0 throughout, `m0_dat_o` = 0x80 on the read ack, and master 1 granted only after release.
- Continuous dual requests for 8 transactions. Expect grants alternating 0, 1, 0, 1, … with no overlap of `t_cyc_o` between owners.
- With `SPI_WB_ARB_TIMEOUT_EN` and `TIMEOUT` = 4: target never acks. Expect `m1_err_o` pulse exactly 4 cycles after strobe, `t_stb_o` low in that cycle, and arbiter still BUSY until `cyc` drops.
- Assert `rstn` low mid-BUSY. Expect `t_cyc_o` = `t_stb_o` = 0 and `gnt_o` = 00 immediately, without waiting for a clock edge.
